// File: rtl/mmio_csr_if.sv
// CSR port between the store queue and the MMIO register block.
interface mmio_csr_if;
    logic        IN_ce;
    logic        IN_we;
    logic [3:0]  IN_wm;
    logic [29:0] IN_addr;
    logic [31:0] IN_data;
    logic [31:0] OUT_data;
    logic        OUT_IO_busy;

    modport master (
        output IN_ce, IN_we, IN_wm, IN_addr, IN_data,
        input  OUT_data, OUT_IO_busy
    );

    modport slave (
        input  IN_ce, IN_we, IN_wm, IN_addr, IN_data,
        output OUT_data, OUT_IO_busy
    );
endinterface

// File: rtl/mmio_csr.sv
// CSR-page register block: 64-bit cycle counter with coherent high-word snapshot,
// byte-masked scratch register and a mode-0, MSB-first byte-wide SPI transmitter.
module mmio_csr #(
    parameter int unsigned SPI_DIV = 2
) (
    input  logic      clk,
    input  logic      rst,
    mmio_csr_if.slave bus,
    output logic      OUT_SPI_clk,
    output logic      OUT_SPI_mosi,
    output logic      OUT_SPI_cs
);
    localparam int unsigned CYC_W  = 64;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIV_W  = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);

    localparam logic [2:0] A_CYC_LO  = 3'd0;
    localparam logic [2:0] A_CYC_HI  = 3'd1;
    localparam logic [2:0] A_SCRATCH = 3'd2;
    localparam logic [2:0] A_SPI_TX  = 3'd3;
    localparam logic [2:0] A_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } spi_state_e;

    logic [CYC_W-1:0]  cyc_q;
    logic [DATA_W-1:0] shadow_hi_q;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata_c;
    logic              ovf_q, ovf_d;
    logic              busy_q;

    spi_state_e        state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;

    logic [2:0]        addr_c;
    logic              rd_c, wr_c, start_c;
    logic              unused_addr;

    assign addr_c      = bus.IN_addr[2:0];
    assign rd_c        = !bus.IN_ce && bus.IN_we;
    assign wr_c        = !bus.IN_ce && !bus.IN_we;
    assign start_c     = wr_c && (addr_c == A_SPI_TX) && bus.IN_wm[0];
    assign unused_addr = ^bus.IN_addr[29:3];

    // Read mux; CYC_HI returns the snapshot taken by the last CYC_LO read.
    always_comb begin
        rdata_c = '0;
        case (addr_c)
            A_CYC_LO:  rdata_c = cyc_q[31:0];
            A_CYC_HI:  rdata_c = shadow_hi_q;
            A_SCRATCH: rdata_c = scratch_q;
            A_STATUS:  rdata_c = {30'd0, ovf_q, busy_q};
            default:   rdata_c = '0;
        endcase
    end

    // Scratch byte merge and sticky overflow; a TX write while busy is dropped.
    always_comb begin
        scratch_d = scratch_q;
        ovf_d     = ovf_q;
        if (wr_c && (addr_c == A_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.IN_wm[b]) scratch_d[8*b +: 8] = bus.IN_data[8*b +: 8];
            end
        end
        if (wr_c && (addr_c == A_STATUS) && bus.IN_wm[0]) ovf_d = 1'b0;
        if (start_c && (state_q != S_IDLE))               ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q       <= '0;
            shadow_hi_q <= '0;
            scratch_q   <= '0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            cyc_q     <= cyc_q + CYC_W'(1);
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            if (rd_c) begin
                data_q <= rdata_c;
                if (addr_c == A_CYC_LO) shadow_hi_q <= cyc_q[63:32];
            end
        end
    end

    // SPI next-state: divCnt paces half-periods, data advances on falling toggles.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_SHIFT;
                    shift_d = bus.IN_data[7:0];
                    bit_d   = 3'd7;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    cs_d    = 1'b0;
                    mosi_d  = bus.IN_data[7];
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    if (sclk_q) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        mosi_d  = shift_q[6];
                        if (bit_q == 3'd0) begin
                            state_d = S_DONE;
                            cs_d    = 1'b1;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign bus.OUT_data    = data_q;
    assign bus.OUT_IO_busy = busy_q;
    assign OUT_SPI_clk     = sclk_q;
    assign OUT_SPI_mosi    = mosi_q;
    assign OUT_SPI_cs      = cs_q;
endmodule
